// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter and sequencer for a 4:1 shared bus: grants one requester at a
// time, drives the registered mux select, and registers the selected data with a valid flag.
module mux_arbiter_4 #(
  parameter int size     = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [size:1]   in1,
  input  logic [size:1]   in2,
  input  logic [size:1]   in3,
  input  logic [size:1]   in4,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [size:1]   out,
  output logic            out_valid
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam bit LIMITED = (MAX_HOLD != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state, w_stateNext;
  logic [1:0]    r_owner, w_ownerNext;
  logic [1:0]    r_last, w_lastNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic [3:0]    r_gnt, w_gntNext;
  logic [1:0]    r_sel, w_selNext;
  logic [size:1] r_out, w_outNext;
  logic          r_valid, w_validNext;

  logic [1:0]    w_pick;
  logic [1:0]    w_cand;
  logic          w_found;
  logic          w_release;

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    w_pick  = r_last;
    w_cand  = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_release = !req[r_owner] || (LIMITED && (r_cnt == HOLD_LIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_last  <= w_lastNext;
      r_cnt   <= w_cntNext;
      r_gnt   <= w_gntNext;
      r_sel   <= w_selNext;
      r_out   <= w_outNext;
      r_valid <= w_validNext;
    end
  end

  // Every release drops to IDLE, so a new grant always follows a one-cycle bubble.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_lastNext  = r_last;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = GRANT;
          w_ownerNext = w_pick;
          w_lastNext  = w_pick;
          w_cntNext   = CW'(1);
        end
      end
      GRANT: begin
        if (w_release) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end else if (!(&r_cnt)) begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_gntNext   = (w_stateNext == GRANT) ? (4'b0001 << w_ownerNext) : 4'b0000;
    w_selNext   = (r_state == IDLE && w_found) ? w_pick : r_sel;
    w_validNext = (r_state == GRANT);
    w_outNext   = r_out;
    if (r_state == GRANT) begin
      case (r_sel)
        2'd0:    w_outNext = in1;
        2'd1:    w_outNext = in2;
        2'd2:    w_outNext = in3;
        default: w_outNext = in4;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Bench for mux_arbiter_4: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a behavioural arbiter model.
module tb_mux_arbiter_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] in1, in2, in3, in4;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;

  logic        rstInf;
  logic [3:0]  reqInf;
  logic [3:0]  gntInf;
  logic [1:0]  selInf;
  logic [15:0] outInf;
  logic        validInf;

  int nCompared = 0;
  int nMismatched = 0;

  // Model state: owner of -1 means the bus is idle.
  int          mOwner, mLast, mHeld, mSel;
  logic [15:0] mOut;
  logic        mValid;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] out;
    logic        valid;
  } vec_t;

  vec_t vecs[10];

  mux_arbiter_4 #(.size(16), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
  );

  mux_arbiter_4 #(.size(16), .MAX_HOLD(0)) u_dutInf (
    .clk(clk), .rst(rstInf), .req(reqInf),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .gnt(gntInf), .sel(selInf), .out(outInf), .out_valid(validInf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  // Expected post-edge outputs, derived from the arbitration rules on the pre-edge inputs.
  task automatic modelStep();
    logic [15:0] ins[4];
    ins[0] = in1; ins[1] = in2; ins[2] = in3; ins[3] = in4;
    if (rst) begin
      mOwner = -1; mLast = 3; mHeld = 0; mSel = 0; mOut = '0; mValid = 1'b0;
    end else begin
      mValid = (mOwner >= 0);
      if (mOwner >= 0) mOut = ins[mSel];
      if (mOwner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (mOwner < 0 && req[(mLast + k) % 4]) mOwner = (mLast + k) % 4;
        end
        if (mOwner >= 0) begin
          mSel = mOwner; mLast = mOwner; mHeld = 1;
        end
      end else if (!req[mOwner] || mHeld == 8) begin
        mOwner = -1; mHeld = 0;
      end else begin
        mHeld++;
      end
    end
  endtask

  function automatic logic [3:0] expGnt(input int o);
    return (o < 0) ? 4'b0000 : 4'(1 << o);
  endfunction

  initial begin
    logic [3:0] e;
    rst = 1'b1; req = 4'b0000; rstInf = 1'b1; reqInf = 4'b0000;
    in1 = 16'h1111; in2 = 16'h2222; in3 = 16'hBEEF; in4 = 16'h4444;

    // Reset with all requests high, first grant, then a single 3-cycle request from requester 2.
    vecs[0] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 16'h1111, 1'b1};
    vecs[5] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 16'h1111, 1'b0};
    vecs[6] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 16'hBEEF, 1'b1};
    vecs[7] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 16'hBEEF, 1'b1};
    vecs[8] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 16'hBEEF, 1'b1};
    vecs[9] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 16'hBEEF, 1'b0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].sel));
      checkOutput($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].out));
      checkOutput($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].valid));
    end

    // Rotation: each owner drops its request after two grant cycles.
    applyStimulus(1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("rr%0d gnt first", k), 32'(gnt), 32'(expGnt(k % 4)));
      checkOutput($sformatf("rr%0d sel", k), 32'(sel), 32'(k % 4));
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("rr%0d gnt second", k), 32'(gnt), 32'(expGnt(k % 4)));
      applyStimulus(1'b0, 4'b1111 & ~expGnt(k % 4));
      checkOutput($sformatf("rr%0d gnt idle", k), 32'(gnt), 32'(4'b0000));
    end

    // Hold limit of 8 with two continuous requesters.
    applyStimulus(1'b1, 4'b0000);
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(1'b0, 4'b0011);
      e = (c <= 8) ? 4'b0001 : (c == 9) ? 4'b0000 : (c <= 17) ? 4'b0010 :
          (c == 18) ? 4'b0000 : 4'b0001;
      checkOutput($sformatf("hold c%0d gnt", c), 32'(gnt), 32'(e));
    end

    // Unlimited hold instance keeps the bus for 300 cycles.
    rstInf = 1'b1; reqInf = 4'b1000;
    @(posedge clk); #1;
    rstInf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("inf c%0d gnt", c), 32'(gntInf), 32'(4'b1000));
    end
    reqInf = 4'b0000;

    // Reset during a grant to requester 2, then re-arbitrate from last = 3.
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("midrst pre gnt", 32'(gnt), 32'(4'b0100));
    applyStimulus(1'b0, 4'b0100);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("midrst gnt", 32'(gnt), 32'(4'b0000));
    checkOutput("midrst sel", 32'(sel), 32'(2'd0));
    checkOutput("midrst out", 32'(out), 32'(16'h0000));
    checkOutput("midrst valid", 32'(out_valid), 32'(1'b0));
    applyStimulus(1'b0, 4'b0110);
    checkOutput("midrst regrant", 32'(gnt), 32'(4'b0010));

    // Randomized traffic against the model; requests tend to persist so hold limits are hit.
    rst = 1'b1; req = 4'b0000;
    modelStep();
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) >= 8) req = 4'($urandom);
      in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom); in4 = 16'($urandom);
      modelStep();
      @(posedge clk); #1;
      checkOutput($sformatf("rand c%0d gnt", c), 32'(gnt), 32'(expGnt(mOwner)));
      checkOutput($sformatf("rand c%0d sel", c), 32'(sel), 32'(mSel));
      checkOutput($sformatf("rand c%0d out", c), 32'(out), 32'(mOut));
      checkOutput($sformatf("rand c%0d valid", c), 32'(out_valid), 32'(mValid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_4.md
# mux_arbiter_4

Round-robin arbiter and sequencer for the 4:1 shared-bus multiplexer in the 16-bit datapath. Up to four requesters (register-file write sources, memory port, I/O) contend for one `size`-bit bus. The block grants exactly one at a time with a req/gnt handshake and drives the mux select. It also registers the selected input and flags it valid. A hold limit bounds how long one requester can keep the bus.

## Interface
Parameters:
- `size`, 16, bus data width; data ports are `[size:1]`.
- `MAX_HOLD`, 8, maximum consecutive grant cycles per ownership; 0 means unlimited.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request per requester; bit i = requester i.
- `in1`, `in2`, `in3`, `in4`  input  size  requester data; in1 = requester 0 … in4 = requester 3.
- `gnt`  output  4  one-hot grant, registered; all-zero when idle.
- `sel`  output  2  mux select (00 = in1 … 11 = in4), registered; equals owner index while granted.
- `out`  output  size  registered selected data.
- `out_valid`  output  1  `out` holds data captured under a grant.

## Operation
- Internal state: `state` (IDLE or GRANT), 2-bit `owner`, 2-bit `last` (round-robin pointer), hold counter `cnt` (width ≥ clog2(MAX_HOLD+1)).
- Reset values:
  - state = IDLE, gnt = 0000, sel = 00, out = 0, out_valid = 0.
  - cnt = 0, last = 3, so requester 0 has top priority first.
- IDLE:
  - If req == 0000, stay in IDLE.
  - Otherwise pick the first asserted req in the order last+1, last+2, last+3, last (mod 4).
  - Go to GRANT; set owner = pick, gnt = onehot(pick), sel = pick, cnt = 1, last = pick.
- GRANT, release condition: req[owner] == 0, or (MAX_HOLD ≠ 0 and cnt == MAX_HOLD).
- GRANT, on release: go to IDLE; gnt = 0000; sel holds its last value; cnt = 0.
- GRANT, otherwise: stay; cnt = cnt + 1 (saturating when MAX_HOLD = 0).
- Release always passes through exactly one IDLE cycle (bus turnaround bubble) before the next grant. This applies even if other reqs are pending or the same owner re-requests.
- Data path:
  - Every cycle, out <= selected input (in1..in4 per sel) if state == GRANT, else out holds.
  - out_valid <= (state == GRANT).
- Requests by non-owners during GRANT are ignored until the next IDLE cycle. Requesters keep req asserted until granted; no queuing.
- gnt is never more than one-hot; sel changes only on entry to GRANT.

## Timing
- Grant latency: req sampled high at edge k in IDLE → gnt/sel valid after edge k.
- Data latency: in[owner] at edge k+1 → out after edge k+1, with out_valid = 1. out/out_valid lag gnt by one cycle.
- Normal release: owner's req sampled low at edge m → gnt = 0000 after edge m → out_valid = 0 after edge m+1. Earliest new grant is after edge m+1.
- Forced release: a continuously requesting owner holds gnt for exactly MAX_HOLD cycles, then has one IDLE cycle. It is then re-arbitrated with lowest priority (last = owner).
- Simultaneous requests: resolved purely by rotation from last+1; ties cannot occur.
- Owner drops req on the same edge another raises req: release first; the new requester is considered at the IDLE-cycle edge.
- rst high at any edge, including mid-grant, forces all reset values after that edge regardless of req. The first grant is possible at the first edge with rst low.

## Test plan
- Reset:
  - Stimulus: hold rst with req = 1111 for 3 cycles.
  - Response: gnt = 0000, sel = 00, out = 0, out_valid = 0 throughout.
  - Then release rst: gnt = 0001 next cycle.
- Single request:
  - Stimulus: req = 0100, in3 = 16'hBEEF, held 3 cycles then dropped.
  - Response: gnt = 0100 and sel = 10 for 3 cycles; out = BEEF with out_valid high for 3 cycles, one cycle delayed; then gnt = 0000.
- Round-robin rotation:
  - Stimulus: req = 1111, each owner drops req for one cycle after 2 grant cycles, then reasserts.
  - Response: grant order 0, 1, 2, 3, 0, each separated by one idle cycle.
- Hold limit:
  - Stimulus: MAX_HOLD = 8, req = 0011 held constant.
  - Response: gnt = 0001 for exactly 8 cycles, 1 idle cycle, then gnt = 0010 for 8 cycles, then back to 0001.
- Unlimited hold:
  - Stimulus: MAX_HOLD = 0, req = 1000 held 300 cycles.
  - Response: gnt = 1000 continuously, with no release and no counter wrap.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during a grant to requester 2.
  - Response: all outputs return to reset values after that edge.
  - Then, with req = 0110 afterwards, requester 1 is granted first (last = 3).
